// File: rtl/common_pkg.sv
// Shared machine word types used across the pipeline stages.
package common;

    typedef logic [31:0] word_t;
    typedef logic [31:0] instr_t;

endpackage : common

// File: rtl/fetch_pkg.sv
// Types, constants and small PC helpers for the instruction fetch stage.
package fetch_pkg;

    import common::*;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        instr_t instr;
        word_t  pc;
        word_t  pcplus4;
        logic   adel;
    } fetch_out_t;

    localparam word_t RESET_PC_DEFAULT = 32'hBFC0_0000;

    // Sequential successor address; wraps modulo 2^32 without any flag.
    function automatic word_t pc_plus4(input word_t pc);
        return pc + 32'd4;
    endfunction

    // Instruction fetches must be word aligned.
    function automatic logic pc_aligned(input word_t pc);
        return (pc[1:0] == 2'b00);
    endfunction

endpackage : fetch_pkg

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-word reads on the
// instruction bus and hands {instr, pc, pc+4, adel} to decode through a
// one-entry output buffer. Redirects flush the buffer and squash any
// in-flight read; a misaligned PC yields a single address-error entry.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter common::word_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_addr_ok,
    input  logic        ibus_data_ok,
    input  logic [31:0] ibus_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pcplus4,
    output logic        out_adel
);

    fetch_state_t  state_q, state_d;
    common::word_t pc_q, pc_d;
    logic          drop_q, drop_d;
    logic          err_done_q, err_done_d;
    logic          out_valid_q, out_valid_d;
    fetch_out_t    out_q, out_d;

    logic          buf_free_s;
    logic          ibus_req_s;
    logic          accept_s;

    // Next-state, PC, squash flag and output buffer update.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        err_done_d  = err_done_q;
        out_d       = out_q;
        buf_free_s  = !out_valid_q || out_ready;
        out_valid_d = out_valid_q && !out_ready;

        if (state_q == S_REQ) begin
            ibus_req_s = buf_free_s && pc_aligned(pc_q);
        end else begin
            ibus_req_s = 1'b0;
        end
        accept_s = ibus_req_s && ibus_addr_ok;

        if (redirect_valid) begin
            // Redirect wins over everything; an accepted or pending read
            // becomes stale and its data is squashed on return.
            pc_d        = redirect_pc;
            out_valid_d = 1'b0;
            err_done_d  = 1'b0;
            case (state_q)
                S_REQ: begin
                    state_d = accept_s ? S_WAIT : S_REQ;
                    drop_d  = accept_s;
                end
                S_WAIT: begin
                    state_d = ibus_data_ok ? S_REQ : S_WAIT;
                    drop_d  = !ibus_data_ok;
                end
                default: begin
                    state_d = S_REQ;
                    drop_d  = 1'b0;
                end
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (!pc_aligned(pc_q)) begin
                        state_d    = S_ERR;
                        err_done_d = 1'b0;
                    end else if (accept_s) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (ibus_data_ok && drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (ibus_data_ok) begin
                        out_d       = '{instr: ibus_rdata, pc: pc_q,
                                        pcplus4: pc_plus4(pc_q), adel: 1'b0};
                        out_valid_d = 1'b1;
                        pc_d        = pc_plus4(pc_q);
                        state_d     = S_REQ;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_ERR: begin
                    // Emit exactly one error entry, then idle until redirected.
                    if (!err_done_q && buf_free_s) begin
                        out_d       = '{instr: 32'h0000_0000, pc: pc_q,
                                        pcplus4: pc_plus4(pc_q), adel: 1'b1};
                        out_valid_d = 1'b1;
                        err_done_d  = 1'b1;
                    end else begin
                        state_d = S_ERR;
                    end
                end
                default: begin
                    state_d = S_REQ;
                    drop_d  = 1'b0;
                end
            endcase
        end
    end

    // State, PC and output buffer registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            err_done_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_q      <= drop_d;
            err_done_q  <= err_done_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    // Bus request is held low while reset is asserted so every output reads 0.
    assign ibus_req    = ibus_req_s && resetn;
    assign ibus_addr   = (resetn && (state_q == S_REQ) && pc_aligned(pc_q)) ? pc_q : 32'h0000_0000;

    assign out_valid   = out_valid_q;
    assign out_instr   = out_q.instr;
    assign out_pc      = out_q.pc;
    assign out_pcplus4 = out_q.pcplus4;
    assign out_adel    = out_q.adel;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a bus responder with configurable
// latency, directed scenarios, then randomized traffic with redirects,
// all checked against an architectural model of the expected entry stream.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_addr_ok = 1'b0;
    logic        ibus_data_ok = 1'b0;
    logic [31:0] ibus_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pcplus4;
    logic        out_adel;

    fetch_unit dut (
        .clk(clk), .resetn(resetn),
        .ibus_req(ibus_req), .ibus_addr(ibus_addr),
        .ibus_addr_ok(ibus_addr_ok), .ibus_data_ok(ibus_data_ok), .ibus_rdata(ibus_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_pcplus4(out_pcplus4), .out_adel(out_adel)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // bus responder state
    logic        pending = 1'b0;
    logic        pend_stale = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          dcnt = 0;

    // architectural model: next entry decode should see
    logic [31:0] exp_pc = 32'hBFC0_0000;
    logic        exp_live = 1'b1;
    int          nhs = 0;
    int          adel_hs = 0;

    // stimulus controls
    int          rdy_mode = 1;   // 0 random, 1 always ready, 2 never ready
    int          aok_mode = 1;   // 1 accept at once, 0 random
    int          dly_fix = 2;    // data latency after accept; 0 = random 1..3
    logic        redir_v = 1'b0;
    logic        redir_on_data = 1'b0;
    logic [31:0] redir_pc = 32'h0;

    logic        last_req, last_aok, last_dok;
    logic [31:0] last_addr;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h2408_0001;
        return a ^ 32'h5A3C_96E1;
    endfunction

    // Compare an observed value against the expected one and count mismatches.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, check, update model at the rising edge.
    task automatic cycle();
        logic hs;
        logic exp_adel;
        out_ready    = (rdy_mode == 0) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
        ibus_addr_ok = 1'b0;
        ibus_data_ok = 1'b0;
        ibus_rdata   = 32'h0;
        if (pending && dcnt == 0) begin
            ibus_data_ok = 1'b1;
            ibus_rdata   = pend_stale ? 32'hDEAD_BEEF : mem(pend_addr);
        end
        redirect_valid = redir_on_data ? ibus_data_ok : redir_v;
        redirect_pc    = redir_pc;
        #1;
        if (ibus_req && !pending)
            ibus_addr_ok = (aok_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        last_req  = ibus_req;
        last_addr = ibus_addr;
        last_aok  = ibus_addr_ok;
        last_dok  = ibus_data_ok;
        hs        = out_valid && out_ready;

        if (ibus_req) begin
            chk("req_aligned", ibus_addr[1:0], 2'b00);
            chk("one_outstanding", pending, 1'b0);
        end
        if (!exp_live) chk("idle_after_adel", ibus_req, 1'b0);
        if (ibus_addr_ok && !redirect_valid && exp_live)
            chk("fetch_addr", ibus_addr, out_valid ? exp_pc + 32'd4 : exp_pc);
        if (out_valid) begin
            exp_adel = (exp_pc[1:0] != 2'b00);
            chk("entry_expected", exp_live, 1'b1);
            chk("out_pc", out_pc, exp_pc);
            chk("out_pcplus4", out_pcplus4, exp_pc + 32'd4);
            chk("out_adel", out_adel, exp_adel);
            chk("out_instr", out_instr, exp_adel ? 32'h0 : mem(exp_pc));
        end

        @(posedge clk);
        if (redirect_valid) begin
            exp_pc   = redirect_pc;
            exp_live = 1'b1;
        end else if (hs) begin
            nhs++;
            if (exp_pc[1:0] != 2'b00) begin
                exp_live = 1'b0;
                adel_hs++;
            end else begin
                exp_pc = exp_pc + 32'd4;
            end
        end
        if (ibus_data_ok) pending = 1'b0;
        else if (pending) dcnt--;
        if (redirect_valid && pending) pend_stale = 1'b1;
        if (last_aok) begin
            pending    = 1'b1;
            pend_addr  = last_addr;
            pend_stale = redirect_valid;
            dcnt       = (dly_fix > 0) ? dly_fix - 1 : int'($urandom_range(0, 2));
        end
        @(negedge clk);
    endtask

    task automatic redirect(input logic [31:0] pc);
        redir_v  = 1'b1;
        redir_pc = pc;
        cycle();
        redir_v  = 1'b0;
    endtask

    // Assert reset for one edge, check all outputs are 0, release at a falling edge.
    task automatic do_reset();
        resetn         = 1'b0;
        redirect_valid = 1'b0;
        ibus_addr_ok   = 1'b0;
        ibus_data_ok   = 1'b0;
        out_ready      = 1'b0;
        #1;
        chk("rst_req", ibus_req, 1'b0);
        chk("rst_addr", ibus_addr, 32'h0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_pcplus4", out_pcplus4, 32'h0);
        chk("rst_adel", out_adel, 1'b0);
        @(posedge clk);
        @(negedge clk);
        exp_pc   = 32'hBFC0_0000;
        exp_live = 1'b1;
        if (pending) pend_stale = 1'b1;
        resetn = 1'b1;
    endtask

    initial begin
        logic [31:0] held_pc, held_instr, tmp;
        logic        saw_beef;
        int          k, n_req, adel0;

        // Reset and first fetch: addr_ok at cycle 1, data_ok at cycle 3.
        rdy_mode = 1; aok_mode = 1; dly_fix = 2;
        do_reset();
        cycle();
        chk("t1_req", last_req, 1'b1);
        chk("t1_addr", last_addr, 32'hBFC0_0000);
        cycle();
        cycle();
        chk("t1_dok", last_dok, 1'b1);
        chk("t1_valid", out_valid, 1'b1);
        chk("t1_pc", out_pc, 32'hBFC0_0000);
        chk("t1_pcplus4", out_pcplus4, 32'hBFC0_0004);
        chk("t1_instr", out_instr, 32'h2408_0001);
        cycle();
        chk("t1_next_addr", last_addr, 32'hBFC0_0004);

        // Back-pressure: buffer full, ready low for 5 cycles.
        rdy_mode = 2; dly_fix = 1;
        for (k = 0; k < 10 && !out_valid; k++) cycle();
        chk("t2_fill", out_valid, 1'b1);
        held_pc = out_pc;
        held_instr = out_instr;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t2_no_req", last_req, 1'b0);
            chk("t2_stable_pc", out_pc, held_pc);
            chk("t2_stable_instr", out_instr, held_instr);
        end
        rdy_mode = 1;
        cycle();
        chk("t2_resume_req", last_req, 1'b1);
        chk("t2_resume_addr", last_addr, held_pc + 32'd4);

        // Redirect while waiting for data: the returned word is squashed.
        dly_fix = 3;
        redirect(32'h8000_0180);
        saw_beef = 1'b0;
        for (k = 0; k < 10; k++) begin
            if (out_valid && out_instr == 32'hDEAD_BEEF) saw_beef = 1'b1;
            cycle();
            if (last_aok) break;
        end
        chk("t3_no_stale", saw_beef, 1'b0);
        chk("t3_aok", last_aok, 1'b1);
        chk("t3_addr", last_addr, 32'h8000_0180);

        // Redirect coinciding with data_ok.
        dly_fix = 2; redir_on_data = 1'b1; redir_pc = 32'h8000_1000;
        for (k = 0; k < 6; k++) begin
            cycle();
            if (last_dok) break;
        end
        redir_on_data = 1'b0;
        chk("t4_dok", last_dok, 1'b1);
        chk("t4_valid", out_valid, 1'b0);
        cycle();
        chk("t4_req", last_req, 1'b1);
        chk("t4_addr", last_addr, 32'h8000_1000);

        // Misaligned redirect: one adel entry, no bus activity.
        adel0 = adel_hs;
        n_req = 0;
        redirect(32'h8000_0002);
        for (int i = 0; i < 12; i++) begin
            cycle();
            n_req += int'(last_req);
        end
        chk("t5_no_req", n_req, 32'd0);
        chk("t5_one_adel", adel_hs - adel0, 32'd1);
        chk("t5_idle", out_valid, 1'b0);

        // Wrap at the top of the address space.
        redirect(32'hFFFF_FFFC);
        for (k = 0; k < 10 && !out_valid; k++) cycle();
        chk("t6_pc", out_pc, 32'hFFFF_FFFC);
        chk("t6_pcplus4", out_pcplus4, 32'h0);
        for (k = 0; k < 5; k++) begin
            cycle();
            if (last_aok) break;
        end
        chk("t6_wrap_addr", last_addr, 32'h0);

        // Randomized traffic with random redirects and one mid-run reset.
        rdy_mode = 0; aok_mode = 0; dly_fix = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                do_reset();
                continue;
            end
            redir_v = ($urandom_range(0, 15) == 0);
            tmp = $urandom;
            case ($urandom_range(0, 7))
                0: begin
                    tmp[1:0] = 2'($urandom_range(1, 3));
                    redir_pc = tmp;
                end
                1: redir_pc = 32'hFFFF_FFF4;
                default: redir_pc = {tmp[31:2], 2'b00};
            endcase
            cycle();
        end
        redir_v = 1'b0;
        chk("progress", nhs > 100, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fetch_unit
